// File: rtl/rf_write_arbiter_pkg.sv
// +----------------------------------------------------------------------+
// | rf_write_arbiter_pkg: register-file geometry shared by write-back.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package rf_write_arbiter_pkg;

  localparam int RF_AW    = 3;
  localparam int RF_DW    = 32;
  localparam int RF_DEPTH = 1 << RF_AW;
  localparam int RF_NREQ  = 3;

  // Successor of a requester index in round-robin order.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rf_write_arbiter_rr.sv
// +----------------------------------------------------------------------+
// | rr_arbiter: round-robin one-hot grant; owns the rotating pointer.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module rr_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int NREQ = RF_NREQ
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic [NREQ-1:0]           req,
  input  logic                      accept,
  output logic [NREQ-1:0]           grant,
  output logic [$clog2(NREQ)-1:0]   grant_idx
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0] r_ptr;
  logic [PW:0]   w_pos;
  logic          w_found;

  // Search starts at the pointer and wraps, so the last winner goes to the back.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    w_pos     = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_pos = {1'b0, r_ptr} + (PW+1)'(k);
      if (w_pos >= (PW+1)'(NREQ)) begin
        w_pos = w_pos - (PW+1)'(NREQ);
      end
      if (!w_found && req[w_pos[PW-1:0]]) begin
        w_found                 = 1'b1;
        grant[w_pos[PW-1:0]]    = 1'b1;
        grant_idx               = w_pos[PW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_ptr <= '0;
    end else if (accept) begin
      r_ptr <= PW'(rr_next(int'(grant_idx), NREQ));
    end
  end

endmodule

`default_nettype wire

// File: rtl/rf_write_arbiter.sv
// +----------------------------------------------------------------------+
// | rf_write_arbiter: shares the RF write port round-robin and keeps the |
// | per-register busy scoreboard used by issue stall logic.  Rev 1.0     |
// +----------------------------------------------------------------------+
`default_nettype none

module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int NREQ = RF_NREQ,
  parameter int AW   = RF_AW,
  parameter int DW   = RF_DW
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 rsv_valid,
  input  logic [AW-1:0]        rsv_addr,
  output logic                 rf_we,
  output logic [AW-1:0]        rf_wa,
  output logic [DW-1:0]        rf_wd,
  output logic [(1<<AW)-1:0]   busy
);

  localparam int PW    = $clog2(NREQ);
  localparam int DEPTH = 1 << AW;

  logic [NREQ-1:0]  w_grant;
  logic [PW-1:0]    w_idx;
  logic             w_accept;
  logic [AW-1:0]    w_addr;
  logic [DW-1:0]    w_data;
  logic [DEPTH-1:0] w_set;
  logic [DEPTH-1:0] w_clr;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .clk       (clk),
    .n_rst     (n_rst),
    .req       (req_valid),
    .accept    (w_accept),
    .grant     (w_grant),
    .grant_idx (w_idx)
  );

  // Grants are suppressed while reset is held so nothing is accepted then.
  assign req_ready = n_rst ? w_grant : '0;
  assign w_accept  = |req_ready;

  always_comb begin
    w_addr = req_addr[int'(w_idx)*AW +: AW];
    w_data = req_data[int'(w_idx)*DW +: DW];
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rf_we <= 1'b0;
      rf_wa <= '0;
      rf_wd <= '0;
    end else if (w_accept) begin
      rf_we <= 1'b1;
      rf_wa <= w_addr;
      rf_wd <= w_data;
    end else begin
      rf_we <= 1'b0;
    end
  end

  generate
    for (genvar r = 0; r < DEPTH; r++) begin : g_sb
      assign w_set[r] = rsv_valid && (rsv_addr == AW'(r));
      assign w_clr[r] = rf_we && (rf_wa == AW'(r));
    end
  endgenerate

  // Set beats clear: a reservation landing with the old write keeps the bit.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      busy <= '0;
    end else begin
      busy <= (busy & ~w_clr) | w_set;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_rf_write_arbiter: vector table + write scoreboard for the arbiter. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_rf_write_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 3;
  localparam int DW   = 32;

  logic               clk = 1'b0;
  logic               n_rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               rsv_valid;
  logic [AW-1:0]      rsv_addr;
  logic               rf_we;
  logic [AW-1:0]      rf_wa;
  logic [DW-1:0]      rf_wd;
  logic [7:0]         busy;

  typedef struct {
    logic [2:0] valid;
    logic [2:0] a0;
    logic       rsv;
    logic [2:0] raddr;
    logic [2:0] exp_ready;
    logic [7:0] exp_busy;
  } vec_t;

  typedef struct {
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
  } wr_t;

  vec_t tbl[$];
  wr_t  sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic [AW-1:0] addr [NREQ];
  logic [DW-1:0] data [NREQ];

  rf_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .rf_we     (rf_we),
    .rf_wa     (rf_wa),
    .rf_wd     (rf_wd),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_addr = '0;
    req_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*AW +: AW] = addr[i];
      req_data[i*DW +: DW] = data[i];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [2:0] v, input logic [2:0] a0, input logic rsv,
                     input logic [2:0] ra, input logic [2:0] er, input logic [7:0] eb);
    vec_t t;
    t.valid = v; t.a0 = a0; t.rsv = rsv; t.raddr = ra; t.exp_ready = er; t.exp_busy = eb;
    tbl.push_back(t);
  endtask

  // One clock: check grant/busy, retire any scoreboard entry, record new accepts.
  task automatic tick(input logic [2:0] er, input logic [7:0] eb, input string tag);
    wr_t e;
    wr_t n;
    @(negedge clk);
    chk({tag, " ready"}, 64'(req_ready), 64'(er));
    chk({tag, " busy"}, 64'(busy), 64'(eb));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, " rf_we"}, 64'(rf_we), 64'(1'b1));
      chk({tag, " rf_wa"}, 64'(rf_wa), 64'(e.wa));
      chk({tag, " rf_wd"}, 64'(rf_wd), 64'(e.wd));
    end else begin
      chk({tag, " rf_we idle"}, 64'(rf_we), 64'(1'b0));
    end
    for (int i = 0; i < NREQ; i++) begin
      if (er[i]) begin
        n.wa = addr[i];
        n.wd = data[i];
        sb.push_back(n);
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (er[i]) data[i] = $urandom;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    wr_t n;
    n_rst     = 1'b0;
    req_valid = '0;
    rsv_valid = 1'b0;
    rsv_addr  = '0;
    addr[0] = 3'd5; addr[1] = 3'd6; addr[2] = 3'd7;
    data[0] = 32'hDEADBEEF; data[1] = $urandom; data[2] = $urandom;

    repeat (3) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    #1;
    chk("reset rf_we", 64'(rf_we), 64'(0));
    chk("reset rf_wa", 64'(rf_wa), 64'(0));
    chk("reset rf_wd", 64'(rf_wd), 64'(0));
    chk("reset busy", 64'(busy), 64'(0));
    chk("reset ready", 64'(req_ready), 64'(0));
    @(posedge clk);
    #1;

    // single request, then idle
    add(3'b001, 3'd5, 0, 0, 3'b001, 8'h00);
    add(3'b000, 3'd1, 0, 0, 3'b000, 8'h00);
    add(3'b000, 3'd1, 0, 0, 3'b000, 8'h00);
    // realign pointer to 0, then six back-to-back round-robin grants
    add(3'b100, 3'd1, 0, 0, 3'b100, 8'h00);
    add(3'b111, 3'd1, 0, 0, 3'b001, 8'h00);
    add(3'b111, 3'd1, 0, 0, 3'b010, 8'h00);
    add(3'b111, 3'd1, 0, 0, 3'b100, 8'h00);
    add(3'b111, 3'd1, 0, 0, 3'b001, 8'h00);
    add(3'b111, 3'd1, 0, 0, 3'b010, 8'h00);
    add(3'b111, 3'd1, 0, 0, 3'b100, 8'h00);
    // wrap fairness from pointer 2
    add(3'b010, 3'd1, 0, 0, 3'b010, 8'h00);
    add(3'b011, 3'd1, 0, 0, 3'b001, 8'h00);
    add(3'b110, 3'd1, 0, 0, 3'b010, 8'h00);
    add(3'b110, 3'd1, 0, 0, 3'b100, 8'h00);
    add(3'b010, 3'd1, 0, 0, 3'b010, 8'h00);
    add(3'b000, 3'd1, 0, 0, 3'b000, 8'h00);
    // pointer holds across idle cycles
    add(3'b100, 3'd1, 0, 0, 3'b100, 8'h00);
    add(3'b000, 3'd1, 0, 0, 3'b000, 8'h00);
    add(3'b000, 3'd1, 0, 0, 3'b000, 8'h00);
    add(3'b000, 3'd1, 0, 0, 3'b000, 8'h00);
    add(3'b000, 3'd1, 0, 0, 3'b000, 8'h00);
    add(3'b101, 3'd1, 0, 0, 3'b001, 8'h00);
    add(3'b100, 3'd1, 0, 0, 3'b100, 8'h00);
    // requester 2 waits two cycles with data held
    add(3'b111, 3'd1, 0, 0, 3'b001, 8'h00);
    add(3'b111, 3'd1, 0, 0, 3'b010, 8'h00);
    add(3'b111, 3'd1, 0, 0, 3'b100, 8'h00);
    // scoreboard: reserve, clear on landing write, reserve racing a landing write
    add(3'b000, 3'd1, 1, 3, 3'b000, 8'h00);
    add(3'b001, 3'd3, 0, 0, 3'b001, 8'h08);
    add(3'b000, 3'd1, 0, 0, 3'b000, 8'h08);
    add(3'b001, 3'd3, 0, 0, 3'b001, 8'h00);
    add(3'b000, 3'd1, 1, 3, 3'b000, 8'h00);
    add(3'b000, 3'd1, 1, 3, 3'b000, 8'h08);
    add(3'b000, 3'd1, 1, 6, 3'b000, 8'h08);
    add(3'b010, 3'd1, 0, 0, 3'b010, 8'h48);
    add(3'b000, 3'd1, 0, 0, 3'b000, 8'h48);
    add(3'b000, 3'd1, 0, 0, 3'b000, 8'h08);

    for (int v = 0; v < tbl.size(); v++) begin
      req_valid = tbl[v].valid;
      addr[0]   = tbl[v].a0;
      rsv_valid = tbl[v].rsv;
      rsv_addr  = tbl[v].raddr;
      tick(tbl[v].exp_ready, tbl[v].exp_busy, $sformatf("v%0d", v));
    end

    // reset arriving while a write is on the output port
    req_valid = 3'b001;
    addr[0]   = 3'd2;
    rsv_valid = 1'b1;
    rsv_addr  = 3'd5;
    tick(3'b001, 8'h08, "rst_pre");
    rsv_valid = 1'b0;
    chk("mid rf_we", 64'(rf_we), 64'(1));
    chk("mid busy", 64'(busy), 64'h28);
    #2;
    n_rst = 1'b0;
    #1;
    chk("async rf_we", 64'(rf_we), 64'(0));
    chk("async rf_wa", 64'(rf_wa), 64'(0));
    chk("async rf_wd", 64'(rf_wd), 64'(0));
    chk("async busy", 64'(busy), 64'(0));
    chk("async ready", 64'(req_ready), 64'(0));
    sb.delete();
    req_valid = 3'b010;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("hold%0d ready", c), 64'(req_ready), 64'(0));
      chk($sformatf("hold%0d rf_we", c), 64'(rf_we), 64'(0));
    end
    n_rst = 1'b1;
    #1;
    chk("release ready", 64'(req_ready), 64'(3'b010));
    n.wa = addr[1];
    n.wd = data[1];
    sb.push_back(n);
    @(posedge clk);
    #1;
    req_valid = '0;
    tick(3'b000, 8'h00, "post_rst");
    tick(3'b000, 8'h00, "post_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
